// File: rtl/nanorv32_mem_arbiter.sv
// nanorv32_mem_arbiter: routes fetch and data requests onto a ROM read port and a RAM port,
// sharing the ROM between both masters with a fair last-grant bit.
module nanorv32_mem_arbiter #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_codemem_req,
  input  logic [31:0]   cpu_codemem_addr,
  output logic [31:0]   codemem_cpu_rdata,
  output logic          codemem_cpu_ack,
  input  logic          cpu_datamem_req,
  input  logic          cpu_datamem_wr,
  input  logic [31:0]   cpu_datamem_addr,
  input  logic [31:0]   cpu_datamem_wdata,
  input  logic [3:0]    cpu_datamem_bytesel,
  output logic [31:0]   datamem_cpu_rdata,
  output logic          datamem_cpu_ack,
  output logic [AW-3:0] rom_addr,
  input  logic [31:0]   rom_rdata,
  output logic [AW-3:0] ram_addr,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          bus_err
);
  typedef enum logic [1:0] {SRC_ERR, SRC_ROM, SRC_RAM} src_t;
  src_t code_src, data_src;
  logic last_code;
  logic code_rom, data_rom, data_ram, data_rd_rom, cont, code_gnt, data_gnt;
  assign code_rom    = cpu_codemem_addr[31:AW] == '0;
  assign data_rom    = cpu_datamem_addr[31:AW] == '0;
  assign data_ram    = cpu_datamem_addr[31:AW+1] == '0 && cpu_datamem_addr[AW];
  assign data_rd_rom = cpu_datamem_req && !cpu_datamem_wr && data_rom;
  assign cont        = cpu_codemem_req && code_rom && data_rd_rom;
  // last_code set means code won the previous contention, so data wins this one
  assign code_gnt    = rst_n && cpu_codemem_req && !(cont && last_code);
  assign data_gnt    = rst_n && cpu_datamem_req && !(cont && !last_code);
  assign rom_addr    = (data_gnt && data_rd_rom) ? cpu_datamem_addr[AW-1:2] : cpu_codemem_addr[AW-1:2];
  assign ram_addr    = cpu_datamem_addr[AW-1:2];
  assign ram_wdata   = cpu_datamem_wdata;
  assign ram_we      = (data_gnt && cpu_datamem_wr && data_ram) ? cpu_datamem_bytesel : 4'b0;
  assign codemem_cpu_rdata = code_src == SRC_ROM ? rom_rdata : 32'h0;
  assign datamem_cpu_rdata = data_src == SRC_ROM ? rom_rdata : data_src == SRC_RAM ? ram_rdata : 32'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codemem_cpu_ack <= 1'b0;
      datamem_cpu_ack <= 1'b0;
      code_src        <= SRC_ERR;
      data_src        <= SRC_ERR;
      last_code       <= 1'b1;
      bus_err         <= 1'b0;
    end else begin
      codemem_cpu_ack <= code_gnt;
      datamem_cpu_ack <= data_gnt;
      code_src        <= (code_gnt && code_rom) ? SRC_ROM : SRC_ERR;
      data_src        <= (!data_gnt || cpu_datamem_wr) ? SRC_ERR : data_rom ? SRC_ROM : data_ram ? SRC_RAM : SRC_ERR;
      if (cont)
        last_code <= code_gnt;
      // fetch outside ROM, data to ERR, or data write into ROM
      if ((code_gnt && !code_rom) || (data_gnt && !data_ram && (cpu_datamem_wr || !data_rom)))
        bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// tb_nanorv32_mem_arbiter: directed scenarios plus randomized masters checked against
// a transaction-level reference model with its own ROM/RAM images.
module tb_nanorv32_mem_arbiter;
  localparam int AW = 15;
  localparam int WORDS = 1 << (AW - 2);
  logic          clk, rst_n;
  logic          creq, dreq, dwr;
  logic [31:0]   caddr, daddr, dwdata;
  logic [3:0]    dbs;
  logic [31:0]   codemem_cpu_rdata, datamem_cpu_rdata, rom_rdata, ram_rdata, ram_wdata;
  logic          codemem_cpu_ack, datamem_cpu_ack, bus_err;
  logic [AW-3:0] rom_addr, ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   rom_mem [0:WORDS-1];
  logic [31:0]   ram_mem [0:WORDS-1];
  logic [31:0]   ref_ram [0:WORDS-1];
  int n_chk = 0, n_fail = 0;
  bit data_turn, ref_err;
  bit gc, gd;
  nanorv32_mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_codemem_req(creq), .cpu_codemem_addr(caddr),
    .codemem_cpu_rdata(codemem_cpu_rdata), .codemem_cpu_ack(codemem_cpu_ack),
    .cpu_datamem_req(dreq), .cpu_datamem_wr(dwr), .cpu_datamem_addr(daddr),
    .cpu_datamem_wdata(dwdata), .cpu_datamem_bytesel(dbs),
    .datamem_cpu_rdata(datamem_cpu_rdata), .datamem_cpu_ack(datamem_cpu_ack),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .bus_err(bus_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rom_rdata <= rom_mem[rom_addr];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end
  initial for (int i = 0; i < WORDS; i++) ram_mem[i] <= 32'(i) * 32'h9E37_79B1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // 0 = ROM, 1 = RAM, 2 = error region
  function automatic int region(logic [31:0] a);
    if (a < (32'd1 << AW)) return 0;
    if (a < (32'd2 << AW)) return 1;
    return 2;
  endfunction
  function automatic logic [31:0] gen_addr(bit allow_err);
    int r = $urandom_range(0, 15);
    if (allow_err && r == 15) return (32'($urandom) | 32'h0001_0000) & 32'hffff_fffc;
    if (r < 8) return 32'($urandom_range(0, 63)) << 2;
    return 32'h8000 + (32'($urandom_range(0, 63)) << 2);
  endfunction
  // One bus cycle: inputs are already driven; predicts grants, then checks the N+1 response.
  task automatic cycle(output bit g_c, output bit g_d);
    int cr = region(caddr), dr = region(daddr);
    bit cont = creq && cr == 0 && dreq && !dwr && dr == 0;
    logic [31:0] ecd, edd;
    logic [3:0] ewe;
    g_c = creq && !(cont && data_turn);
    g_d = dreq && !(cont && !data_turn);
    if (cont) data_turn = !data_turn;
    ewe = (g_d && dwr && dr == 1) ? dbs : 4'b0;
    ecd = (g_c && cr == 0) ? rom_mem[caddr[AW-1:2]] : 32'h0;
    edd = (!g_d || dwr) ? 32'h0 : dr == 0 ? rom_mem[daddr[AW-1:2]] : dr == 1 ? ref_ram[daddr[AW-1:2]] : 32'h0;
    if (g_d && dwr && dr == 1)
      for (int b = 0; b < 4; b++)
        if (dbs[b]) ref_ram[daddr[AW-1:2]][8*b +: 8] = dwdata[8*b +: 8];
    if ((g_c && cr != 0) || (g_d && (dr == 2 || (dwr && dr == 0)))) ref_err = 1'b1;
    #1 chk("ram_we", {28'h0, ram_we}, {28'h0, ewe});
    @(posedge clk);
    #1;
    chk("code_ack", {31'h0, codemem_cpu_ack}, {31'h0, g_c});
    chk("code_rdata", codemem_cpu_rdata, ecd);
    chk("data_ack", {31'h0, datamem_cpu_ack}, {31'h0, g_d});
    chk("data_rdata", datamem_cpu_rdata, edd);
    chk("bus_err", {31'h0, bus_err}, {31'h0, ref_err});
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    creq = 0; dreq = 0; dwr = 0; caddr = 0; daddr = 0; dwdata = 0; dbs = 0;
    #1;
    chk("rst_code_ack", {31'h0, codemem_cpu_ack}, 32'h0);
    chk("rst_data_ack", {31'h0, datamem_cpu_ack}, 32'h0);
    chk("rst_code_rdata", codemem_cpu_rdata, 32'h0);
    chk("rst_data_rdata", datamem_cpu_rdata, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    data_turn = 1'b1;
    ref_err = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      rom_mem[i] = $urandom;
      ref_ram[i] = 32'(i) * 32'h9E37_79B1;
    end
    rom_mem[0] = 32'h11; rom_mem[1] = 32'h22; rom_mem[2] = 32'h33;
    do_reset();
    // continuous fetch
    creq = 1; caddr = 32'h0;
    cycle(gc, gd); chk("fetch0", codemem_cpu_rdata, 32'h11);
    caddr = 32'h4;
    cycle(gc, gd); chk("fetch1", codemem_cpu_rdata, 32'h22);
    caddr = 32'h8;
    cycle(gc, gd); chk("fetch2", codemem_cpu_rdata, 32'h33);
    chk("fetch2_ack", {31'h0, codemem_cpu_ack}, 32'h1);
    // ROM contention: data first, then fetch, then fetch wins the next one
    caddr = 32'h100; dreq = 1; dwr = 0; daddr = 32'h200;
    cycle(gc, gd);
    chk("cont1_dack", {31'h0, datamem_cpu_ack}, 32'h1);
    chk("cont1_cack", {31'h0, codemem_cpu_ack}, 32'h0);
    dreq = 0;
    cycle(gc, gd);
    chk("cont1_cack_late", {31'h0, codemem_cpu_ack}, 32'h1);
    dreq = 1;
    cycle(gc, gd);
    chk("cont2_cack", {31'h0, codemem_cpu_ack}, 32'h1);
    chk("cont2_dack", {31'h0, datamem_cpu_ack}, 32'h0);
    creq = 0;
    cycle(gc, gd);
    chk("cont2_dack_late", {31'h0, datamem_cpu_ack}, 32'h1);
    // partial RAM write then read back
    dwr = 1; daddr = 32'h8004; dwdata = 32'hDEAD_BEEF; dbs = 4'b0011;
    cycle(gc, gd);
    dwr = 0;
    cycle(gc, gd);
    chk("ram_rb_low", {16'h0, datamem_cpu_rdata[15:0]}, 32'h0000_BEEF);
    // faulting write to ROM, then read of the error region
    dwr = 1; daddr = 32'h0010; dwdata = 32'h1234_5678; dbs = 4'hf;
    cycle(gc, gd);
    chk("rom_wr_err", {31'h0, bus_err}, 32'h1);
    dwr = 0; daddr = 32'h0001_0000;
    cycle(gc, gd);
    chk("err_rd_data", datamem_cpu_rdata, 32'h0);
    dreq = 0;
    cycle(gc, gd);
    chk("err_sticky", {31'h0, bus_err}, 32'h1);
    // reset right after a fetch is accepted discards its ack
    creq = 1; caddr = 32'h4;
    @(posedge clk);
    do_reset();
    creq = 1; caddr = 32'h8;
    cycle(gc, gd);
    chk("post_rst_fetch", codemem_cpu_rdata, 32'h33);
    creq = 0;
    cycle(gc, gd);
    // randomized masters that hold requests until granted
    for (int n = 0; n < 3000; n++) begin
      if (gc || !creq) begin
        creq = $urandom_range(0, 3) != 0;
        caddr = gen_addr(n > 1500);
      end
      if (gd || !dreq) begin
        dreq = $urandom_range(0, 3) != 0;
        dwr = $urandom_range(0, 2) == 0;
        daddr = gen_addr(n > 1500);
        dwdata = $urandom;
        dbs = 4'($urandom);
      end
      cycle(gc, gd);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/nanorv32_mem_arbiter.md
NANORV32_MEM_ARBITER -- requirements
Module: nanorv32_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, giving the per-memory byte-address width (32 KB ROM, 32 KB RAM).
REQ-002 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port cpu_codemem_req, input, 1, the instruction-fetch request.
REQ-005 SHALL have port cpu_codemem_addr, input, 32, the fetch byte address.
REQ-006 SHALL have port codemem_cpu_rdata, output, 32, the fetch data.
REQ-007 SHALL have port codemem_cpu_ack, output, 1, the fetch acknowledge.
REQ-008 SHALL have port cpu_datamem_req, input, 1, the data request.
REQ-009 SHALL have port cpu_datamem_wr, input, 1, meaning 1 = write, 0 = read.
REQ-010 SHALL have port cpu_datamem_addr, input, 32, the data byte address.
REQ-011 SHALL have port cpu_datamem_wdata, input, 32, the write data.
REQ-012 SHALL have port cpu_datamem_bytesel, input, 4, the byte lanes.
REQ-013 SHALL have port datamem_cpu_rdata, output, 32, the data read data.
REQ-014 SHALL have port datamem_cpu_ack, output, 1, the data acknowledge.
REQ-015 SHALL have port rom_addr, output, AW-2, the ROM word address; ROM read port only.
REQ-016 SHALL have port rom_rdata, input, 32, the ROM data, valid one cycle after the address.
REQ-017 SHALL have port ram_addr, output, AW-2, the RAM word address.
REQ-018 SHALL have port ram_we, output, 4, the RAM byte write enables.
REQ-019 SHALL have port ram_wdata, output, 32, the RAM write data.
REQ-020 SHALL have port ram_rdata, input, 32, the RAM data, one-cycle latency.
REQ-021 SHALL have port bus_err, output, 1, the sticky access-error flag.

Function
REQ-022 SHALL decode addresses as follows:
- addr[31:AW+1]==0 and addr[AW]==0: ROM.
- addr[31:AW+1]==0 and addr[AW]==1: RAM.
- anything else: ERR.
REQ-023 SHALL route fetches to ROM or ERR only; a fetch decoding to RAM is treated as ERR.
REQ-024 SHALL define acceptance: a request is accepted in cycle N when req=1 and it is granted in N.
- An ungranted request is not accepted; the master holds req/addr/wdata/bytesel until its ack.
REQ-025 SHALL assert the matching ack for exactly one cycle in N+1 for every request accepted in N, and never otherwise.
- Back-to-back accepts give continuous ack, one transaction per cycle.
REQ-026 SHALL arbitrate ROM contention (fetch and data read both target ROM in cycle N) with a last-grant bit:
- grant the port not granted at the last contention;
- after reset, data wins the first contention;
- the loser is accepted at the earliest cycle it wins, so no port waits more than 1 cycle.
REQ-027 SHALL always grant data requests to RAM or ERR, and fetches when there is no ROM contention; fetch-to-RAM and data-to-ROM proceed in the same cycle.
REQ-028 SHALL drive rom_addr from the granted ROM requester's addr[AW-1:2]; ram_addr SHALL be cpu_datamem_addr[AW-1:2].
REQ-029 SHALL set ram_we = bytesel only for an accepted data write to RAM, else 4'b0; ram_wdata = cpu_datamem_wdata.
REQ-030 SHALL mux read data in N+1 from a per-port source register captured at accept:
- ROM source: rom_rdata.
- RAM source: ram_rdata.
- ERR source or write: 32'h0.
REQ-031 SHALL drive rdata to 0 in cycles without ack.
REQ-032 SHALL handle faulting accesses as follows:
- data write to ROM: dropped, acked normally, sets bus_err;
- any ERR access: acked in N+1 with rdata 0, write dropped, sets bus_err;
- bus_err is cleared only by reset.
REQ-033 SHALL apply no write-to-read forwarding: a read of a RAM word written in the previous cycle returns RAM behaviour.

Reset
REQ-034 SHALL, while rst_n=0, hold outputs as follows:
- codemem_cpu_ack, datamem_cpu_ack, bus_err: 0;
- both rdata: 0;
- ram_we: 0;
- last-grant: "code", so data wins first;
- source registers: ERR.
REQ-035 SHALL discard transactions accepted in the cycle reset asserts (no ack after release), and accept nothing until the first edge with rst_n=1.

Verification
REQ-036 SHALL cover continuous fetch from 0x0,0x4,0x8 with ROM holding 0x11,0x22,0x33 -> ack high from cycle 1, rdata 0x11,0x22,0x33 on consecutive cycles.
REQ-037 SHALL cover a same-cycle fetch of 0x100 and data read of 0x200 -> data acked N+1; fetch acked N+2; next contention grants fetch first.
REQ-038 SHALL cover a write 0xDEADBEEF, bytesel 4'b0011, to 0x8004, then a read -> ram_we=0011 for one cycle; read returns 0x????BEEF per RAM model.
REQ-039 SHALL cover a write to 0x0010, then a read of 0x10000 -> both acked N+1; ram_we stays 0; rdata 0; bus_err=1 and stays 1.
REQ-040 SHALL cover rst_n asserted the cycle after accepting a fetch -> no ack; all outputs 0; normal operation after release.
